jtcps1_pal_dma: RTL and testbench

- Bus-master DMA engine that copies palette data from VRAM into the internal palette buffer.
- Sits beside the main 68000 block. It drives that block's busreq input and consumes its busack output.
- Once the CPU releases the bus, the engine owns the shared VRAM/SDRAM port and copies the enabled palette pages, one word at a time.
- It is triggered by a palette-control MMR write decoded in the PPU.

---
 rtl/jtcps1_pal_dma.sv | 163 ++++++++++++++++
 tb/tb_jtcps1_pal_dma.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcps1_pal_dma.sv
// Palette DMA: copies enabled palette pages from VRAM into the palette buffer.
// Ports: clk/rst (async, active-high), cen; LVBL; pal_copy trigger with
//   pal_base / pal_page_en; busreq/busack handshake with the main CPU block;
//   VRAM read port (vram_addr, vram_cs, vram_data, vram_ok); palette buffer
//   write port (pal_we, pal_addr, pal_data); busy status.
// Macro JTCPS1_PALDMA_VBLANK_EN: hold accepted triggers until LVBL falls.
module jtcps1_pal_dma #(
   parameter int PAGES   = 6,
   parameter int PAGE_AW = 9
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               cen,
   input  logic               LVBL,
   input  logic               pal_copy,
   input  logic [15:0]        pal_base,
   input  logic [PAGES-1:0]   pal_page_en,
   output logic               busreq,
   input  logic               busack,
   output logic [16:0]        vram_addr,
   output logic               vram_cs,
   input  logic [15:0]        vram_data,
   input  logic               vram_ok,
   output logic               pal_we,
   output logic [PAGE_AW+2:0] pal_addr,
   output logic [15:0]        pal_data,
   output logic               busy
);

`ifdef JTCPS1_PALDMA_VBLANK_EN
   localparam bit VBLANK = 1'b1;
`else
   localparam bit VBLANK = 1'b0;
`endif

   localparam int PGW = 3;

   typedef enum logic [2:0] {IDLE, REQ, RD, WR, NEXT, REL} state_t;

   state_t             st, st_nx;
   logic               pending, armed, lvbl_l, skip;
   logic [9:0]         sh_base;
   logic [PAGES-1:0]   sh_mask;
   logic [PGW-1:0]     page, first_pg, nx_pg;
   logic [PAGE_AW-1:0] off;
   logic [16:0]        src;
   logic               first_any, nx_any, trig, fall, last_off;
   logic               unused_base;

   assign unused_base = ^pal_base[15:10];
   assign trig        = pal_copy | pending;
   assign fall        = VBLANK & lvbl_l & ~LVBL;
   assign last_off    = &off;

   // lowest enabled page in the incoming mask, and the next
   // enabled page above the current one in the shadow mask
   always_comb begin
      first_any = 1'b0;
      first_pg  = '0;
      for (int i = PAGES-1; i >= 0; i--) begin
         if (pal_page_en[i]) begin
            first_any = 1'b1;
            first_pg  = PGW'(i);
         end
      end
      nx_any = 1'b0;
      nx_pg  = page;
      for (int i = PAGES-1; i >= 0; i--) begin
         if (sh_mask[i] && i > int'(page)) begin
            nx_any = 1'b1;
            nx_pg  = PGW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= IDLE;
      else     st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      if (cen) begin
         unique case (st)
            IDLE: begin
               if (armed) begin
                  if (fall) st_nx = REQ;
               end else if (trig) begin
                  if (!first_any)  st_nx = REL;
                  else if (VBLANK) st_nx = IDLE;
                  else             st_nx = REQ;
               end
            end
            REQ:  if (busack) st_nx = RD;
            RD:   if (busack && !skip && vram_ok) st_nx = WR;
            WR:   st_nx = NEXT;
            NEXT: st_nx = (last_off && !nx_any) ? REL : RD;
            REL:  st_nx = IDLE;
            default: st_nx = IDLE;
         endcase
      end
   end

   assign busreq    = st == REQ || st == RD || st == WR || st == NEXT;
   assign vram_cs   = st == RD && busack;
   assign pal_we    = st == WR && cen;
   assign vram_addr = {sh_base, 7'd0} + src;
   assign pal_addr  = {page, off};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= 1'b0;
         armed    <= 1'b0;
         lvbl_l   <= 1'b0;
         skip     <= 1'b0;
         sh_base  <= '0;
         sh_mask  <= '0;
         page     <= '0;
         off      <= '0;
         src      <= '0;
         pal_data <= '0;
         busy     <= 1'b0;
      end else begin
         // a trigger arriving outside IDLE (or off cen) is queued once
         if (pal_copy) pending <= 1'b1;
         if (cen) begin
            lvbl_l <= LVBL;
            unique case (st)
               IDLE: begin
                  if (!armed && trig) begin
                     pending <= 1'b0;
                     sh_base <= pal_base[9:0];
                     sh_mask <= pal_page_en;
                     page    <= first_pg;
                     off     <= '0;
                     src     <= '0;
                     skip    <= 1'b1;
                     busy    <= 1'b1;
                     armed   <= VBLANK & first_any;
                  end else if (fall) begin
                     armed   <= 1'b0;
                  end
               end
               RD: begin
                  // the first cycle of a (re)issued read may carry stale data
                  if (!busack)      skip     <= 1'b1;
                  else if (skip)    skip     <= 1'b0;
                  else if (vram_ok) pal_data <= vram_data;
               end
               NEXT: begin
                  src  <= src + 17'd1;
                  off  <= off + PAGE_AW'(1);
                  skip <= 1'b1;
                  if (last_off) page <= nx_pg;
               end
               REL: busy <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Testbench for jtcps1_pal_dma: VRAM and bus-grant models, a write
// scoreboard fed by the stimulus, and a negedge monitor that drains it.
module tb_jtcps1_pal_dma;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b1;
   logic        LVBL;
   logic        pal_copy = 1'b0;
   logic [15:0] pal_base = '0;
   logic [5:0]  pal_page_en = '0;
   logic        busreq;
   logic        busack = 1'b0;
   logic [16:0] vram_addr;
   logic        vram_cs;
   logic [15:0] vram_data;
   logic        vram_ok;
   logic        pal_we;
   logic [11:0] pal_addr;
   logic [15:0] pal_data;
   logic        busy;

   int checks = 0, fails = 0;
   int nwr = 0, req_rises = 0, busy_cyc = 0;

   typedef struct packed {
      logic [11:0] a;
      logic [15:0] d;
   } wr_t;
   wr_t sb[$];
   wr_t exp_w;

   jtcps1_pal_dma dut (
      .clk(clk), .rst(rst), .cen(cen), .LVBL(LVBL),
      .pal_copy(pal_copy), .pal_base(pal_base),
      .pal_page_en(pal_page_en), .busreq(busreq), .busack(busack),
      .vram_addr(vram_addr), .vram_cs(vram_cs), .vram_data(vram_data),
      .vram_ok(vram_ok), .pal_we(pal_we), .pal_addr(pal_addr),
      .pal_data(pal_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // random clock enable during one test
   logic cen_rand = 1'b0;
   always @(posedge clk) cen <= cen_rand ? ($urandom_range(3) != 0) : 1'b1;

   // vertical blank generator, or manual control
   logic lvbl_auto = 1'b1, lvbl_man = 1'b1;
   int   lv_cnt = 0;
   always @(posedge clk) lv_cnt <= (lv_cnt == 299) ? 0 : lv_cnt + 1;
   assign LVBL = lvbl_auto ? (lv_cnt < 280) : lvbl_man;

   function automatic logic [15:0] vmem(input logic [16:0] a);
      return a[15:0] ^ 16'hC35A;
   endfunction

   // VRAM: first cycle of a read shows stale data flagged valid,
   // real data after 1..4 further cycles depending on the address
   int unsigned vcnt = 0;
   always @(posedge clk) vcnt <= vram_cs ? vcnt + 1 : 0;
   assign vram_ok = vram_cs &&
      (vcnt == 0 || vcnt >= 32'(vram_addr[1:0]) + 1);
   assign vram_data = (vcnt == 0) ? 16'hDEAD : vmem(vram_addr);

   // CPU bus grant: follows busreq after 3 cycles, can be forced low
   logic [2:0] req_sh = '0;
   logic       ack_drop = 1'b0;
   always @(posedge clk) begin
      req_sh <= {req_sh[1:0], busreq};
      busack <= req_sh[2] && busreq && !ack_drop;
   end

   logic busreq_q = 1'b0, cs_q = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         busreq_q <= 1'b0;
         cs_q     <= 1'b0;
      end else begin
         if (pal_we) begin
            nwr    = nwr + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
               fails = fails + 1;
               $display("FAIL sb_extra: write addr=%0d data=%h, none expected",
                        pal_addr, pal_data);
            end else begin
               exp_w = sb.pop_front();
               if (pal_addr !== exp_w.a || pal_data !== exp_w.d) begin
                  fails = fails + 1;
                  $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h",
                           pal_addr, pal_data, exp_w.a, exp_w.d);
               end
            end
         end
         if (busreq && !busreq_q) req_rises = req_rises + 1;
         if (!busreq && busreq_q) begin
            checks = checks + 1;
            if (cs_q) begin
               fails = fails + 1;
               $display("FAIL busreq_fall: fell while vram_cs=%b, want 0", cs_q);
            end
         end
         if (busy) busy_cyc = busy_cyc + 1;
         busreq_q <= busreq;
         cs_q     <= vram_cs;
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_xfer(input logic [15:0] base, input logic [5:0] mask);
      int   src = 0;
      wr_t  e;
      logic [16:0] a;
      for (int p = 0; p < 6; p++) begin
         if (mask[p]) begin
            for (int o = 0; o < 512; o++) begin
               a   = {base[9:0], 7'd0} + 17'(src);
               e.a = 12'(p * 512 + o);
               e.d = vmem(a);
               sb.push_back(e);
               src++;
            end
         end
      end
   endtask

   task automatic pulse();
      @(posedge clk); #1 pal_copy = 1'b1;
      @(posedge clk); #1 pal_copy = 1'b0;
   endtask

   task automatic trigger(input logic [15:0] base, input logic [5:0] mask);
      pal_base    = base;
      pal_page_en = mask;
      pulse();
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy || busreq) && n < budget) begin
         tick(1);
         n++;
      end
      checks = checks + 1;
      if (n >= budget) begin
         fails = fails + 1;
         $display("FAIL %s: transfer not done after %0d cycles, %0d writes left",
                  name, n, sb.size());
      end
      tick(5);
      chk({name, "_busreq"}, 32'(busreq), 0);
      chk({name, "_busy"}, 32'(busy), 0);
   endtask

   task automatic wait_sig(input string name, input int budget, input bit ack);
      int n = 0;
      while (((ack ? busack : vram_cs) !== 1'b1) && n < budget) begin
         tick(1);
         n++;
      end
      checks = checks + 1;
      if (n >= budget) begin
         fails = fails + 1;
         $display("FAIL %s: signal not high after %0d cycles, want high", name, n);
      end
   endtask

   int n0, r0;

   initial begin
      rst = 1'b1;
      tick(3);
      chk("rst_busreq", 32'(busreq), 0);
      chk("rst_vram_cs", 32'(vram_cs), 0);
      chk("rst_pal_we", 32'(pal_we), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_vram_addr", 32'(vram_addr), 0);
      chk("rst_pal_addr", 32'(pal_addr), 0);
      chk("rst_pal_data", 32'(pal_data), 0);
      rst = 1'b0;
      tick(2);

      // single page, first-read latency
      n0 = nwr; r0 = req_rises;
      push_xfer(16'h0090, 6'b000001);
      trigger(16'h0090, 6'b000001);
`ifndef JTCPS1_PALDMA_VBLANK_EN
      chk("t1_req_next", 32'(busreq), 1);
`endif
      wait_sig("t1_ack", 1000, 1'b1);
      chk("t1_cs_at_ack", 32'(vram_cs), 0);
      tick(1);
      chk("t1_cs_after_ack", 32'(vram_cs), 1);
      chk("t1_first_addr", 32'(vram_addr), 32'h04800);
      wait_done("t1", 8000);
      chk("t1_nwr", 32'(nwr - n0), 512);
      chk("t1_req_rises", 32'(req_rises - r0), 1);

      // two sparse pages, random clock enable
      n0 = nwr;
      cen_rand = 1'b1;
      push_xfer(16'h1234, 6'b100100);
      trigger(16'h1234, 6'b100100);
      wait_done("t2", 30000);
      cen_rand = 1'b0;
      chk("t2_nwr", 32'(nwr - n0), 1024);

      // empty mask
      r0 = req_rises;
      busy_cyc = 0;
      trigger(16'h0090, 6'b000000);
      tick(20);
      chk("t3_no_req", 32'(req_rises - r0), 0);
      chk("t3_busy_pulse", 32'(busy_cyc >= 1 && busy_cyc <= 2), 1);

      // retriggers while busy queue exactly one more transfer
      n0 = nwr; r0 = req_rises;
      push_xfer(16'h0100, 6'b000010);
      push_xfer(16'h0100, 6'b000010);
      trigger(16'h0100, 6'b000010);
      tick(50);
      pulse();
      tick(7);
      pulse();
      wait_done("t4", 16000);
      chk("t4_nwr", 32'(nwr - n0), 1024);
      chk("t4_req_rises", 32'(req_rises - r0), 2);

      // bus grant withdrawn mid-page
      n0 = nwr;
      push_xfer(16'h0200, 6'b000001);
      trigger(16'h0200, 6'b000001);
      begin
         int n = 0;
         while (nwr - n0 < 100 && n < 3000) begin
            tick(1);
            n++;
         end
         chk("t5_reach_100", 32'(nwr - n0), 100);
      end
      ack_drop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("t5_gap_cs", 32'(vram_cs), 0);
      end
      chk("t5_gap_busreq", 32'(busreq), 1);
      ack_drop = 1'b0;
      wait_sig("t5_resume", 50, 1'b0);
      chk("t5_resume_addr", 32'(vram_addr), 32'h10064);
      wait_done("t5", 8000);
      chk("t5_nwr", 32'(nwr - n0), 512);

      // reset during a read with a stale retrigger pending
      trigger(16'h0300, 6'b000001);
      tick(3);
      pulse();
      wait_sig("t6_rd", 2000, 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_busreq", 32'(busreq), 0);
      chk("t6_cs", 32'(vram_cs), 0);
      chk("t6_we", 32'(pal_we), 0);
      chk("t6_busy", 32'(busy), 0);
      sb.delete();
      tick(3);
      rst = 1'b0;
      r0 = req_rises;
      tick(400);
      chk("t6_stale_req", 32'(req_rises - r0), 0);
      chk("t6_idle_busy", 32'(busy), 0);

`ifdef JTCPS1_PALDMA_VBLANK_EN
      // trigger held until LVBL falls
      lvbl_auto = 1'b0;
      lvbl_man  = 1'b1;
      tick(3);
      push_xfer(16'h0090, 6'b000001);
      trigger(16'h0090, 6'b000001);
      tick(20);
      chk("t7_wait_busreq", 32'(busreq), 0);
      chk("t7_wait_busy", 32'(busy), 1);
      lvbl_man = 1'b0;
      #1;
      chk("t7_fall_busreq", 32'(busreq), 0);
      tick(1);
      chk("t7_req_after_fall", 32'(busreq), 1);
      wait_done("t7", 8000);
      lvbl_auto = 1'b1;
`endif

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
               checks - fails, checks);
      $fatal(1);
   end

endmodule
